// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared constants and state type for the binary-to-BCD converter
package bin2bcd_pkg;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] BCD_NINE   = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 to a BCD digit that is 5 or more
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    // Pre-shift correction so the following left shift carries correctly into the next digit
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= ADJ_THRESH) begin
            o_digit = i_digit + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative shift-and-add-3 binary-to-BCD converter with saturation and blanking
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int SCR_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_finish;

    logic [BIN_W-1:0]   r_shreg;
    logic [SCR_W-1:0]   r_scratch;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;

    logic [SCR_W-1:0]   w_adj;
    logic [SCR_W-1:0]   w_scratch_next;
    logic               w_ovf_next;
    logic [SCR_W-1:0]   w_result;
    logic [DIGITS-1:0]  w_blank_next;
    logic               w_zero_run;

    logic               r_done;
    logic [SCR_W-1:0]   r_bcd;
    logic               r_overflow;
    logic [DIGITS-1:0]  r_blank;

    // All digits are corrected in parallel from the pre-shift scratch value
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // One shift step: the top binary bit enters the ones digit; the bit leaving the top digit marks overflow
    assign w_scratch_next = {w_adj[SCR_W-2:0], r_shreg[BIN_W-1]};
    assign w_ovf_next     = r_ovf | w_adj[SCR_W-1];
    assign w_result       = w_ovf_next ? {DIGITS{BCD_NINE}} : w_scratch_next;

    // Leading-zero mask: digit i blanks when it and every higher digit are zero; ones digit always shown
    always_comb begin
        w_blank_next = '0;
        w_zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run      = w_zero_run & (w_result[i*DIGIT_W +: DIGIT_W] == 4'd0);
            w_blank_next[i] = w_zero_run;
        end
        if (w_ovf_next) begin
            w_blank_next = '0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and step control; start is only looked at in IDLE so it cannot disturb a running conversion
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_finish     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: capture on start, shift once per cycle, register results on the last shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg    <= '0;
            r_scratch  <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_blank    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_shreg   <= bin_in;
                r_scratch <= '0;
                r_ovf     <= 1'b0;
                r_cnt     <= CNT_W'(BIN_W);
            end else if (r_state == SHIFT) begin
                r_shreg   <= r_shreg << 1;
                r_scratch <= w_scratch_next;
                r_ovf     <= w_ovf_next;
                r_cnt     <= r_cnt - CNT_W'(1);
                if (w_finish) begin
                    r_bcd      <= w_result;
                    r_overflow <= w_ovf_next;
                    r_blank    <= w_blank_next;
                    r_done     <= 1'b1;
                end
            end
        end
    end

    assign busy     = (r_state == SHIFT);
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_overflow;
    assign blank    = r_blank;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq at three parameter points
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;

    logic        start0, start8, start20;
    logic [13:0] bin0;
    logic [7:0]  bin8;
    logic [19:0] bin20;

    logic        busy0, busy8, busy20;
    logic        done0, done8, done20;
    logic [15:0] bcd0;
    logic [11:0] bcd8;
    logic [23:0] bcd20;
    logic        ovf0, ovf8, ovf20;
    logic [3:0]  blank0;
    logic [2:0]  blank8;
    logic [5:0]  blank20;

    int n_vec  = 0;
    int n_miss = 0;
    int sel    = 0;

    logic        cur_done;
    logic [63:0] cur_bcd;
    logic        cur_ovf;
    logic [63:0] cur_blank;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start0), .bin_in(bin0),
        .busy(busy0), .done(done0), .bcd_out(bcd0), .overflow(ovf0), .blank(blank0)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .bin_in(bin8),
        .busy(busy8), .done(done8), .bcd_out(bcd8), .overflow(ovf8), .blank(blank8)
    );

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut20 (
        .clk(clk), .rst(rst), .start(start20), .bin_in(bin20),
        .busy(busy20), .done(done20), .bcd_out(bcd20), .overflow(ovf20), .blank(blank20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur_done  = done0;
        cur_bcd   = 64'(bcd0);
        cur_ovf   = ovf0;
        cur_blank = 64'(blank0);
        if (sel == 1) begin
            cur_done  = done8;
            cur_bcd   = 64'(bcd8);
            cur_ovf   = ovf8;
            cur_blank = 64'(blank8);
        end else if (sel == 2) begin
            cur_done  = done20;
            cur_bcd   = 64'(bcd20);
            cur_ovf   = ovf20;
            cur_blank = 64'(blank20);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] to_bcd(input int unsigned v);
        logic [63:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 16; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int unsigned b2b_val(input int j);
        return 17 + 211 * j;
    endfunction

    // Called on a negedge; runs one conversion on DUT s and checks latency, results and pulse width
    task automatic convert(input int s, input int unsigned v, input int lat,
                           input logic [63:0] exp_bcd, input logic exp_ovf,
                           input logic [63:0] exp_blank, input string tag);
        int cyc;
        sel = s;
        case (s)
            1:       begin bin8  = 8'(v);  start8  = 1'b1; end
            2:       begin bin20 = 20'(v); start20 = 1'b1; end
            default: begin bin0  = 14'(v); start0  = 1'b1; end
        endcase
        @(negedge clk);
        start0 = 1'b0; start8 = 1'b0; start20 = 1'b0;
        bin0 = '1; bin8 = '1; bin20 = '1;
        cyc = 0;
        while (!cur_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"},   64'(cyc), 64'(lat));
        chk({tag, "_bcd"},   cur_bcd, exp_bcd);
        chk({tag, "_ovf"},   64'(cur_ovf), 64'(exp_ovf));
        chk({tag, "_blank"}, cur_blank, exp_blank);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(cur_done), 64'd0);
        chk({tag, "_hold"},  cur_bcd, exp_bcd);
    endtask

    initial begin
        int seen_done;
        rst = 1'b1;
        start0 = 1'b0; start8 = 1'b0; start20 = 1'b0;
        bin0 = '0; bin8 = '0; bin20 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(busy0),  64'd0);
        chk("rst_done",  64'(done0),  64'd0);
        chk("rst_bcd",   64'(bcd0),   64'd0);
        chk("rst_ovf",   64'(ovf0),   64'd0);
        chk("rst_blank", 64'(blank0), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        convert(0, 1234, 14, 64'h1234, 1'b0, 64'b0000, "v1234");

        // Abort mid-conversion: start 5678, reset lands on the sixth edge after acceptance
        bin0 = 14'd5678; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy_pre", 64'(busy0), 64'd1);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy",  64'(busy0),  64'd0);
        chk("abort_bcd",   64'(bcd0),   64'd0);
        chk("abort_ovf",   64'(ovf0),   64'd0);
        chk("abort_blank", 64'(blank0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0) seen_done = 1;
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);

        convert(0, 9999,  14, 64'h9999, 1'b0, 64'b0000, "v9999");
        convert(0, 10000, 14, 64'h9999, 1'b1, 64'b0000, "v10000");
        convert(0, 16383, 14, 64'h9999, 1'b1, 64'b0000, "v16383");
        convert(0, 0,     14, 64'h0000, 1'b0, 64'b1110, "v0");
        convert(0, 7,     14, 64'h0007, 1'b0, 64'b1110, "v7");
        convert(0, 40,    14, 64'h0040, 1'b0, 64'b1100, "v40");
        convert(0, 305,   14, 64'h0305, 1'b0, 64'b1000, "v305");

        // Back-to-back: start held, bin_in changes every cycle; accepts land on edges 0, 15, 30, 45
        start0 = 1'b1;
        for (int j = 0; j < 47; j++) begin
            bin0 = 14'(b2b_val(j));
            @(negedge clk);
            chk("b2b_done", 64'(done0), 64'((j % 15) == 14));
            if ((j % 15) == 14) begin
                chk("b2b_bcd", 64'(bcd0), to_bcd(b2b_val(j - 14)));
            end
        end
        start0 = 1'b0;
        repeat (20) @(negedge clk);

        convert(1, 255,     8,  64'h255,    1'b0, 64'b000,    "w8_255");
        convert(1, 9,       8,  64'h009,    1'b0, 64'b110,    "w8_9");
        convert(2, 999999,  20, 64'h999999, 1'b0, 64'b000000, "w20_999999");
        convert(2, 1000000, 20, 64'h999999, 1'b1, 64'b000000, "w20_1000000");
        convert(2, 42,      20, 64'h000042, 1'b0, 64'b111100, "w20_42");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
